// File: rtl/load_register_if.sv
// Signal bundle for a load_register: parallel data in, load enable, registered data out.
// Used by benches and wrappers that connect to the block's plain ports.
interface load_register_if #(
  parameter int unsigned WIDTH = 4
) (
  input logic clk
);
  logic [WIDTH-1:0] din;
  logic             ld;
  logic [WIDTH-1:0] qout;

  modport master (
    input  clk,
    output din,
    output ld,
    input  qout
  );

  modport slave (
    input  clk,
    input  din,
    input  ld,
    output qout
  );
endinterface

// File: rtl/load_register.sv
// WIDTH-bit parallel-load register with load enable and asynchronous active-high reset.
// The port list is positional-compatible with older instantiations: (I, Q, ld, clk, rst).
module load_register #(
  parameter int unsigned     WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] Q,
  input  logic             ld,
  input  logic             clk,
  input  logic             rst
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  always_comb begin
    q_d = q_q;
    if (ld) begin
      q_d = I;
    end
  end

  // Reset wins over load on every edge and also acts between edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= RESET_VALUE;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q = q_q;

endmodule

// File: tb/tb_load_register.sv
// Directed bench for load_register: reset hold, load, hold, async reset, back-to-back loads,
// plus a wide instance with a non-zero reset value. A reference model is checked after each edge.
module tb_load_register;

  logic       clk;
  logic       rst;
  logic [7:0] din8;
  logic       ld8;
  logic [7:0] q8;

  int unsigned n_vec;
  int unsigned n_err;
  logic [3:0]  exp_q;

  load_register_if #(.WIDTH(4)) bus (.clk(clk));

  load_register #(.WIDTH(4)) dut (
    .I   (bus.din),
    .Q   (bus.qout),
    .ld  (bus.ld),
    .clk (clk),
    .rst (rst)
  );

  load_register #(.WIDTH(8), .RESET_VALUE(8'hA5)) dut8 (
    .I   (din8),
    .Q   (q8),
    .ld  (ld8),
    .clk (clk),
    .rst (rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model for the 4-bit instance, compared one step after each clk or rst rise.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q = 4'b0000;
    end else if (bus.ld === 1'b1) begin
      exp_q = bus.din;
    end
    #1;
    n_vec++;
    if (bus.qout !== exp_q) begin
      n_err++;
      $display("FAIL model_check t=%0t: Q=%b expected %b", $time, bus.qout, exp_q);
    end
  end

  task automatic test_reset();
    rst     = 1'b1;
    bus.din = 4'b0010;
    bus.ld  = 1'b1;
    din8    = 8'h00;
    ld8     = 1'b0;
    #1;
    n_vec++;
    if (bus.qout !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_async: Q=%b expected 0000", bus.qout);
    end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      n_vec++;
      if (bus.qout !== 4'b0000) begin
        n_err++;
        $display("FAIL reset_hold[%0d]: Q=%b expected 0000", k, bus.qout);
      end
      n_vec++;
      if (q8 !== 8'hA5) begin
        n_err++;
        $display("FAIL reset_value_wide[%0d]: Q=%h expected a5", k, q8);
      end
    end
  endtask

  task automatic test_load_after_release();
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++;
    if (bus.qout !== 4'b0000) begin
      n_err++;
      $display("FAIL release_no_edge: Q=%b expected 0000", bus.qout);
    end
    @(posedge clk);
    #1;
    n_vec++;
    if (bus.qout !== 4'b0010) begin
      n_err++;
      $display("FAIL load_after_release: Q=%b expected 0010", bus.qout);
    end
    n_vec++;
    if (q8 !== 8'hA5) begin
      n_err++;
      $display("FAIL wide_no_load_after_release: Q=%h expected a5", q8);
    end
  endtask

  task automatic test_hold();
    @(negedge clk);
    bus.ld  = 1'b0;
    bus.din = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      n_vec++;
      if (bus.qout !== 4'b0010) begin
        n_err++;
        $display("FAIL hold[%0d]: Q=%b expected 0010", k, bus.qout);
      end
    end
    // Pulse ld and wiggle I entirely between edges; nothing should be captured.
    @(negedge clk);
    bus.ld  = 1'b1;
    bus.din = 4'b1010;
    #1;
    bus.ld  = 1'b0;
    bus.din = 4'b0111;
    #1;
    n_vec++;
    if (bus.qout !== 4'b0010) begin
      n_err++;
      $display("FAIL between_edges: Q=%b expected 0010", bus.qout);
    end
    @(posedge clk);
    #1;
    n_vec++;
    if (bus.qout !== 4'b0010) begin
      n_err++;
      $display("FAIL glitch_ignored: Q=%b expected 0010", bus.qout);
    end
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    n_vec++;
    if (bus.qout !== 4'b0000) begin
      n_err++;
      $display("FAIL async_mid_cycle: Q=%b expected 0000", bus.qout);
    end
    @(negedge clk);
    bus.ld  = 1'b1;
    bus.din = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      n_vec++;
      if (bus.qout !== 4'b0000) begin
        n_err++;
        $display("FAIL reset_priority[%0d]: Q=%b expected 0000", k, bus.qout);
      end
    end
    @(negedge clk);
    bus.ld = 1'bx;
    @(posedge clk);
    #1;
    n_vec++;
    if (bus.qout !== 4'b0000) begin
      n_err++;
      $display("FAIL ld_x_in_reset: Q=%b expected 0000", bus.qout);
    end
    @(negedge clk);
    bus.ld = 1'b0;
    rst    = 1'b0;
    @(posedge clk);
    #1;
    n_vec++;
    if (bus.qout !== 4'b0000) begin
      n_err++;
      $display("FAIL release_ld0: Q=%b expected 0000", bus.qout);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] pat [3];
    pat[0] = 4'b1111;
    pat[1] = 4'b0101;
    pat[2] = 4'b1001;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.ld  = 1'b1;
      bus.din = pat[k];
      @(posedge clk);
      #1;
      n_vec++;
      if (bus.qout !== pat[k]) begin
        n_err++;
        $display("FAIL back_to_back[%0d]: Q=%b expected %b", k, bus.qout, pat[k]);
      end
    end
    @(negedge clk);
    bus.ld = 1'b0;
  endtask

  task automatic test_wide();
    @(negedge clk);
    ld8  = 1'b1;
    din8 = 8'h3C;
    @(posedge clk);
    #1;
    n_vec++;
    if (q8 !== 8'h3C) begin
      n_err++;
      $display("FAIL wide_load: Q=%h expected 3c", q8);
    end
    @(negedge clk);
    ld8  = 1'b0;
    din8 = 8'hFF;
    @(posedge clk);
    #1;
    n_vec++;
    if (q8 !== 8'h3C) begin
      n_err++;
      $display("FAIL wide_hold: Q=%h expected 3c", q8);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_load_after_release();
    test_hold();
    test_async_reset();
    test_back_to_back();
    test_wide();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
